// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory port arbiter.
// Holds the FSM encoding, the IO window select and the legal transfer lengths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] IO_SEL = 2'b11;

    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_4 = 3'd4;

    // Anything other than 1 or 2 bytes becomes a full word.
    function automatic logic [2:0] legal_len(input logic [2:0] len);
        case (len)
            LEN_1, LEN_2: return len;
            default:      return LEN_4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant, search starts just after ptr.
// Zero latency; no grant when no request is present.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_CH-1:0] gnt
);

    int            pos;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            idx = PW'(pos);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising per-channel word requests onto a byte-wide memory.
// Read responds L+2 cycles after grant, write L+1; rdy_in low freezes everything.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int MAX_LEN = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rob_clear,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH-1:0]    req_wr,
    input  logic [NUM_CH-1:0]    req_flushable,
    input  logic [32*NUM_CH-1:0] req_addr,
    input  logic [3*NUM_CH-1:0]  req_len,
    input  logic [32*NUM_CH-1:0] req_wdata,
    output logic [NUM_CH-1:0]    resp_valid,
    output logic [31:0]          resp_data,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr_q, ch_q, gnt_idx;
    logic [NUM_CH-1:0] gnt, req_eff, resp_pend, ch_onehot;
    logic [31:0]       addr_q, wdata_q, rbuf_q, rbuf_nxt, cur_a;
    logic [31:0]       sel_addr, sel_wdata;
    logic [2:0]        sel_len_raw, len_legal, len_sel, len_q, cnt_q;
    logic [1:0]        bidx;
    logic              flush_q, gnt_any, do_grant, io_stall;
    logic              rd_flush, rd_done, wr_done;

    // A channel is masked while its completion pulse is pending, so a requester
    // that drops valid on the pulse is not granted a second time.
    assign req_eff = req_valid & ~resp_pend;

    rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_rr (
        .req (req_eff),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx     = '0;
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_len_raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx     = PW'(i);
                sel_addr    = req_addr[32*i +: 32];
                sel_wdata   = req_wdata[32*i +: 32];
                sel_len_raw = req_len[3*i +: 3];
            end
        end
    end

    assign gnt_any   = |gnt;
    assign len_legal = legal_len(sel_len_raw);
    assign len_sel   = (len_legal > 3'(MAX_LEN)) ? 3'(MAX_LEN) : len_legal;
    assign ch_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_q;

    assign do_grant = (state == IDLE) && rdy_in && !rob_clear && gnt_any;
    assign io_stall = (state == WRITE) && (addr_q[17:16] == IO_SEL) && io_buffer_full;
    assign rd_flush = (state == READ) && rob_clear && flush_q;
    assign rd_done  = (state == READ) && !rd_flush && (cnt_q == len_q);
    assign wr_done  = (state == WRITE) && !io_stall && (cnt_q == len_q - 3'd1);
    assign cur_a    = addr_q + {29'd0, cnt_q};

    // The byte on mem_din belongs to the address issued one count earlier.
    assign bidx = cnt_q[1:0] - 2'd1;
    always_comb begin
        rbuf_nxt = rbuf_q;
        rbuf_nxt[{bidx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rdy_in) begin
            case (state)
                IDLE:    if (do_grant) state_nxt = req_wr[gnt_idx] ? WRITE : READ;
                READ:    if (rd_flush || rd_done) state_nxt = IDLE;
                WRITE:   if (wr_done) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q     <= PW'(NUM_CH - 1);
            ch_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            rbuf_q    <= '0;
            resp_data <= '0;
            resp_pend <= '0;
        end else if (rdy_in) begin
            resp_pend <= '0;
            if (do_grant) begin
                ptr_q   <= gnt_idx;
                ch_q    <= gnt_idx;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                len_q   <= len_sel;
                flush_q <= req_flushable[gnt_idx];
                cnt_q   <= '0;
                rbuf_q  <= '0;
            end else if (rd_flush) begin
                cnt_q  <= '0;
                rbuf_q <= '0;
            end else if (state == READ) begin
                if (cnt_q != 3'd0) begin
                    rbuf_q <= rbuf_nxt;
                end
                if (rd_done) begin
                    resp_data <= rbuf_nxt;
                    resp_pend <= ch_onehot;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end else if ((state == WRITE) && !io_stall) begin
                if (wr_done) begin
                    resp_pend <= ch_onehot;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end
        end
    end

    // A frozen block keeps its address on the bus but never writes or responds.
    assign resp_valid = rdy_in ? resp_pend : '0;
    assign mem_wr     = (state == WRITE) && !io_stall && rdy_in;
    assign mem_dout   = ((state == WRITE) && !io_stall) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

    always_comb begin
        mem_a = '0;
        if (((state == READ) && (cnt_q < len_q)) || ((state == WRITE) && !io_stall)) begin
            mem_a = cur_a;
        end
    end

endmodule
